// File: rtl/dsm_cic_decim.sv
// Second-order CIC decimator: rebuilds unsigned 8-bit samples from a 1-bit
// pulse-density stream, one sample per 2^DECIM_LOG2 enabled clocks.
module dsm_cic_decim #(
    parameter int unsigned DECIM_LOG2 = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enb,
    input  logic       dsm_in,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       settled
);

    localparam int unsigned GW = 2 * DECIM_LOG2;
    localparam int unsigned W  = GW + 1;
    localparam logic [DECIM_LOG2-1:0] CNT_MAX = '1;

    logic [W-1:0]          int1;
    logic [W-1:0]          int2;
    logic [W-1:0]          int2_d;
    logic [W-1:0]          c1_d;
    logic [DECIM_LOG2-1:0] dec_cnt;
    logic                  tick;
    logic [1:0]            n_out;

    logic [W-1:0]    c1_c;
    logic [W-1:0]    c2_c;
    logic [GW+7:0]   frac_ext_c;
    logic [7:0]      scaled_c;
    logic            unused_frac_c;

    // Modulo-2^W differences are exact as long as the true result fits in W bits.
    assign c1_c = int2 - int2_d;
    assign c2_c = c1_c - c1_d;

    // Zero-padding below the fraction keeps the top-8 slice legal for small ratios.
    assign frac_ext_c    = {c2_c[GW-1:0], 8'h00};
    assign scaled_c      = frac_ext_c[GW+7 -: 8];
    assign unused_frac_c = ^frac_ext_c[GW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            int1       <= '0;
            int2       <= '0;
            int2_d     <= '0;
            c1_d       <= '0;
            dec_cnt    <= '0;
            tick       <= 1'b0;
            n_out      <= 2'd0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            settled    <= 1'b0;
        end else begin
            tick       <= 1'b0;
            dout_valid <= 1'b0;

            if (enb) begin
                int1    <= int1 + W'(dsm_in);
                int2    <= int2 + int1;
                dec_cnt <= dec_cnt + DECIM_LOG2'(1);
                tick    <= (dec_cnt == CNT_MAX);
            end

            // Comb/output stage fires on the tick regardless of enb.
            if (tick) begin
                int2_d     <= int2;
                c1_d       <= c1_c;
                dout       <= c2_c[GW] ? 8'hFF : scaled_c;
                dout_valid <= 1'b1;
                if (n_out != 2'd3) begin
                    n_out <= n_out + 2'd1;
                end
                if (n_out == 2'd2) begin
                    settled <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dsm_cic_decim.sv
// Scoreboard bench for dsm_cic_decim: expected pulses are queued as the
// stimulus completes each frame and checked when dout_valid appears.
module tb_dsm_cic_decim;

    localparam int unsigned R = 128;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic       dsm_in;
    logic [7:0] dout;
    logic       dout_valid;
    logic       settled;

    dsm_cic_decim #(.DECIM_LOG2(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .enb        (enb),
        .dsm_in     (dsm_in),
        .dout       (dout),
        .dout_valid (dout_valid),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned edge_no;
        int unsigned idx;
        logic [7:0]  dout;
        bit          chk;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned en_cnt   = 0;
    int unsigned n_push   = 0;
    int unsigned dsm_acc  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, expv, cyc);
        end
    endtask

    // One clock of stimulus; the reference model tracks frames in enabled edges.
    task automatic step(input bit r, input bit e, input bit d, input logic [7:0] exp_d);
        rst    = r;
        enb    = e;
        dsm_in = d;
        if (r) begin
            en_cnt = 0;
            n_push = 0;
            if (sb.size() > 0 && sb[$].edge_no == cyc + 1) void'(sb.pop_back());
        end else if (e) begin
            en_cnt++;
            if (en_cnt % R == 0) begin
                n_push++;
                sb.push_back('{edge_no: cyc + 2, idx: n_push, dout: exp_d, chk: (n_push >= 3)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bit gen_bit(input int pat, input int unsigned k);
        case (pat)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (k % 2 == 0);
            3:       return (k % 4 == 0);
            default: begin
                dsm_acc = dsm_acc + 100;
                if (dsm_acc >= 256) begin
                    dsm_acc = dsm_acc - 256;
                    return 1'b1;
                end
                return 1'b0;
            end
        endcase
    endfunction

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        dsm_acc = 0;
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_settled", 32'(settled), 32'd0);
    endtask

    task automatic run_edges(input int pat, input int unsigned n_edges, input bit gated,
                             input logic [7:0] exp_d);
        for (int unsigned i = 0; i < n_edges; i++) begin
            step(1'b0, 1'b1, gen_bit(pat, en_cnt), exp_d);
            if (gated) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), exp_d);
        end
    endtask

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_edge", 32'(cyc), 32'(e.edge_no));
                check("pulse_settled", 32'(settled), 32'(e.idx >= 3));
                if (e.chk) check("pulse_dout", 32'(dout), 32'(e.dout));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst    = 1'b1;
        enb    = 1'b0;
        dsm_in = 1'b0;

        do_reset();
        run_edges(1, 5 * R, 1'b0, 8'hFF);

        do_reset();
        run_edges(0, 4 * R, 1'b0, 8'h00);

        do_reset();
        run_edges(2, 4 * R, 1'b0, 8'd128);

        do_reset();
        run_edges(3, 4 * R, 1'b0, 8'd64);

        do_reset();
        run_edges(4, 4 * R, 1'b0, 8'd100);

        do_reset();
        run_edges(1, 4 * R, 1'b1, 8'hFF);

        // Reset halfway through the fifth frame.
        do_reset();
        run_edges(1, 4 * R + R / 2, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 1'b1, 8'hFF);
        check("midrst_dout", 32'(dout), 32'd0);
        check("midrst_settled", 32'(settled), 32'd0);
        check("midrst_valid", 32'(dout_valid), 32'd0);
        run_edges(1, 3 * R, 1'b0, 8'hFF);

        // Reset on the edge after a decimation edge: pending tick is discarded.
        run_edges(1, R, 1'b0, 8'hFF);
        step(1'b1, 1'b0, 1'b1, 8'hFF);
        check("tickrst_valid", 32'(dout_valid), 32'd0);
        check("tickrst_settled", 32'(settled), 32'd0);

        // Reset coinciding with what would be the decimation edge.
        run_edges(1, R - 1, 1'b0, 8'hFF);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 1'b0, 8'hFF);
        check("decrst_valid", 32'(dout_valid), 32'd0);
        run_edges(1, 3 * R, 1'b0, 8'hFF);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        check("drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
